// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 key decoder and its FIFO.
//   - scan codes with special meaning (prefixes, shifts, whitespace keys)
//   - prefix FSM state type
//   - scan_to_ascii(): set-2 make code plus shift state to ASCII, with a valid bit
package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  // Wide enough for a count of 16 entries, the largest supported depth.
  localparam int COUNT_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,  // F0 seen
    EXT     = 2'd2,  // E0 seen
    EXT_BRK = 2'd3   // E0 F0 seen
  } prefix_state_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] ascii;
  } map_result_t;

  // Letters honour shift; digits, space, enter and backspace ignore it.
  // Anything else, including the shift keys themselves, is reported invalid.
  function automatic map_result_t scan_to_ascii(input logic [7:0] code,
                                                input logic       shift);
    map_result_t r;
    logic [7:0]  lower;
    r.valid = 1'b1;
    r.ascii = 8'h00;
    case (code)
      8'h1C: lower = "a";
      8'h32: lower = "b";
      8'h21: lower = "c";
      8'h23: lower = "d";
      8'h24: lower = "e";
      8'h2B: lower = "f";
      8'h34: lower = "g";
      8'h33: lower = "h";
      8'h43: lower = "i";
      8'h3B: lower = "j";
      8'h42: lower = "k";
      8'h4B: lower = "l";
      8'h3A: lower = "m";
      8'h31: lower = "n";
      8'h44: lower = "o";
      8'h4D: lower = "p";
      8'h15: lower = "q";
      8'h2D: lower = "r";
      8'h1B: lower = "s";
      8'h2C: lower = "t";
      8'h3C: lower = "u";
      8'h2A: lower = "v";
      8'h1D: lower = "w";
      8'h22: lower = "x";
      8'h35: lower = "y";
      8'h1A: lower = "z";
      default: lower = 8'h00;
    endcase
    if (lower != 8'h00) begin
      // Upper case sits exactly 20h below lower case in ASCII.
      r.ascii = shift ? (lower - 8'h20) : lower;
    end else begin
      case (code)
        8'h45:     r.ascii = "0";
        8'h16:     r.ascii = "1";
        8'h1E:     r.ascii = "2";
        8'h26:     r.ascii = "3";
        8'h25:     r.ascii = "4";
        8'h2E:     r.ascii = "5";
        8'h36:     r.ascii = "6";
        8'h3D:     r.ascii = "7";
        8'h3E:     r.ascii = "8";
        8'h46:     r.ascii = "9";
        SC_SPACE:  r.ascii = 8'h20;
        SC_ENTER:  r.ascii = 8'h0D;
        SC_BKSP:   r.ascii = 8'h08;
        default:   r.valid = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_char_fifo.sv
// ps2_char_fifo: synchronous FIFO of 8-bit characters.
// Ports:
//   inclock, resetn   clock, synchronous active-low reset
//   push, din         write request and data (ignored when full unless popping)
//   pop               read request (ignored when empty)
//   dout              head entry; 8'h00 when empty
//   count             occupied entries, 0..DEPTH
//   full, empty       occupancy flags
module ps2_char_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               inclock,
  input  logic               resetn,
  input  logic               push,
  input  logic [7:0]         din,
  input  logic               pop,
  output logic [7:0]         dout,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == COUNT_W'(DEPTH));
  assign empty = (count == '0);

  // A pop frees a slot on the same edge, so a full FIFO still accepts a
  // push when it is also being read.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = empty ? 8'h00 : mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge inclock) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural overflow of the pointer wraps it.
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; count gates every read, so stale
  // contents are never visible and the array can map onto plain RAM.
  always_ff @(posedge inclock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns a stream of PS/2 set-2 scan bytes into ASCII
// characters buffered in a small FIFO.
// Ports:
//   inclock, resetn        clock, synchronous active-low reset
//   byte_valid, byte_data  one-cycle strobe with a received scan byte
//   out_valid, out_ascii   FIFO head; out_ascii is 8'h00 when empty
//   out_ready              consumer takes the head when out_valid is high
//   fifo_count             occupied FIFO entries
//   shift_active           a Shift key is currently held
//   overflow               sticky: a character was dropped on a full FIFO
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               inclock,
  input  logic               resetn,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               out_valid,
  output logic [7:0]         out_ascii,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] fifo_count,
  output logic               shift_active,
  output logic               overflow
);

  prefix_state_e state;
  map_result_t   map;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          is_shift;

  assign is_shift  = (byte_data == SC_LSHIFT) || (byte_data == SC_RSHIFT);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  // Only a plain make in IDLE can produce a character; prefix bytes and
  // shift codes map as invalid, so they never push.
  // NOTE: every signal driven here gets a value on every path, so no latch
  // is inferred.
  always_comb begin
    map  = scan_to_ascii(byte_data, shift_active);
    push = byte_valid && (state == IDLE) && map.valid;
  end

  always_ff @(posedge inclock) begin
    if (!resetn) begin
      state        <= IDLE;
      shift_active <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (push && full && !pop) overflow <= 1'b1;
      if (byte_valid) begin
        case (state)
          IDLE: begin
            if (byte_data == SC_BREAK)    state <= BRK;
            else if (byte_data == SC_EXT) state <= EXT;
            else if (is_shift)            shift_active <= 1'b1;
          end
          BRK: begin
            if (is_shift) shift_active <= 1'b0;
            state <= IDLE;
          end
          // Extended keys (arrows, right Ctrl/Alt, ...) are not decoded.
          EXT:     state <= (byte_data == SC_BREAK) ? EXT_BRK : IDLE;
          EXT_BRK: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  ps2_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .inclock (inclock),
    .resetn  (resetn),
    .push    (push),
    .din     (map.ascii),
    .pop     (pop),
    .dout    (out_ascii),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed scan-byte sequences push
// their expected characters into a queue; a monitor compares every accepted
// character against the queue head.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  logic        inclock    = 1'b0;
  logic        resetn     = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data  = 8'h00;
  logic        out_ready  = 1'b1;
  logic        out_valid;
  logic [7:0]  out_ascii;
  logic [4:0]  fifo_count;
  logic        shift_active;
  logic        overflow;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];

  ps2_key_decoder #(.FIFO_DEPTH(4)) dut (
    .inclock      (inclock),
    .resetn       (resetn),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .out_valid    (out_valid),
    .out_ascii    (out_ascii),
    .out_ready    (out_ready),
    .fifo_count   (fifo_count),
    .shift_active (shift_active),
    .overflow     (overflow)
  );

  always #5 inclock = ~inclock;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, actual, required);
    end
  endtask

  // Monitor: sample on the falling edge, mid-cycle.
  always @(negedge inclock) begin
    if (resetn) begin
      if (!out_valid) begin
        check("ascii_zero_when_empty", out_ascii, 8'h00);
      end else if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_char: actual %0h required none", out_ascii);
        end else begin
          check("char", out_ascii, exp_q.pop_front());
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge inclock); #1;
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge inclock); #1; end
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    byte_valid = 1'b0;
    @(posedge inclock); #1;
    resetn = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && fifo_count == 0) break;
      @(posedge inclock); #1;
    end
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_count"}, fifo_count, 0);
    idle(2);
  endtask

  task automatic check_idle_state(input string name);
    check({name, "_fsm_idle"}, dut.state, IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, with a strobe that must be ignored.
    byte_valid = 1'b1;
    byte_data  = 8'h1C;
    @(posedge inclock); #1;
    @(posedge inclock); #1;
    byte_valid = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ascii", out_ascii, 8'h00);
    check("rst_count", fifo_count, 0);
    check("rst_shift", shift_active, 0);
    check("rst_overflow", overflow, 0);
    resetn = 1'b1;
    idle(1);

    // 1C F0 1C: one 'a', visible the cycle after the make.
    exp_q.push_back(8'h61);
    send(8'h1C);
    check("lat_out_valid", out_valid, 1);
    check("lat_out_ascii", out_ascii, 8'h61);
    send(8'hF0);
    send(8'h1C);
    wait_drain("make_break");
    check_idle_state("make_break");

    // Left shift around a letter.
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h62);
    send(8'h12);
    check("shift_on", shift_active, 1);
    send(8'h32);
    send(8'hF0);
    send(8'h32);
    check("shift_held", shift_active, 1);
    send(8'hF0);
    send(8'h12);
    check("shift_off", shift_active, 0);
    send(8'h32);
    wait_drain("shift_b");

    // Extended codes discarded, including a mapped code after E0.
    exp_q.push_back(8'h31);
    send(8'hE0); send(8'h75);
    check_idle_state("ext_make");
    send(8'hE0); send(8'hF0); send(8'h75);
    check_idle_state("ext_break");
    send(8'hE0); send(8'h1C);
    send(8'h16);
    wait_drain("ext");
    check_idle_state("ext_done");

    // Right shift, digits ignore shift, whitespace keys, typematic repeat.
    exp_q.push_back(8'h5A); exp_q.push_back(8'h30); exp_q.push_back(8'h20);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h08);
    exp_q.push_back(8'h7A); exp_q.push_back(8'h7A);
    send(8'h59);
    send(8'h1A); send(8'h45); send(8'h29); send(8'h5A); send(8'h66);
    send(8'hF0); send(8'h59);
    send(8'h1A); send(8'h1A);
    send(8'h0E);  // unmapped make
    wait_drain("misc");
    check("misc_overflow", overflow, 0);

    // Overflow: fifth character dropped.
    out_ready = 1'b0;
    exp_q.push_back(8'h71); exp_q.push_back(8'h61);
    exp_q.push_back(8'h62); exp_q.push_back(8'h63);
    send(8'h15); send(8'h1C); send(8'h32); send(8'h21);
    check("ovf_pre_flag", overflow, 0);
    send(8'h29);
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    out_ready = 1'b1;
    wait_drain("ovf");
    check("ovf_sticky", overflow, 1);

    // Push and pop together on a full FIFO.
    do_reset();
    check("rst2_overflow", overflow, 0);
    out_ready = 1'b0;
    exp_q.push_back(8'h71); exp_q.push_back(8'h61);
    exp_q.push_back(8'h62); exp_q.push_back(8'h63);
    exp_q.push_back(8'h20);
    send(8'h15); send(8'h1C); send(8'h32); send(8'h21);
    check("full_count", fifo_count, 4);
    out_ready = 1'b1;
    send(8'h29);
    out_ready = 1'b0;
    check("pushpop_count", fifo_count, 4);
    check("pushpop_overflow", overflow, 0);
    check("pushpop_head", out_ascii, 8'h61);
    out_ready = 1'b1;
    wait_drain("pushpop");

    // Reset mid-sequence discards the prefix and buffered characters.
    out_ready = 1'b0;
    send(8'h1C);            // buffered, then lost to reset
    send(8'hF0);
    resetn     = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'h1C;
    @(posedge inclock); #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_ascii", out_ascii, 8'h00);
    check("midrst_count", fifo_count, 0);
    check("midrst_shift", shift_active, 0);
    check_idle_state("midrst");
    resetn     = 1'b1;
    byte_valid = 1'b0;
    out_ready  = 1'b1;
    idle(2);
    exp_q.push_back(8'h61);
    send(8'h1C);
    wait_drain("midrst");

    check("final_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
